// File: rtl/rvfi_mon_pkg.sv
// Shared types for the RVFI commit merger: retirement packet layout and order-counter width.
package rvfi_mon_pkg;

    localparam int XLEN    = 32;
    localparam int ORDER_W = 64;

    typedef struct packed {
        logic [31:0]       inst;
        logic              trap;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [XLEN-1:0]   rs1_rdata;
        logic [XLEN-1:0]   rs2_rdata;
        logic              load_regfile;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN/8-1:0] mem_rmask;
        logic [XLEN/8-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
    } rvfi_pkt_t;

endpackage

// File: rtl/rvfi_commit_merger_if.sv
// Commit-lane input bus and RVFI-side outputs of the commit merger.
interface rvfi_commit_merger_if
    import rvfi_mon_pkg::*;
#(
    parameter int NUM_PORTS = 2
) ();

    logic [NUM_PORTS-1:0]  in_valid;
    rvfi_pkt_t [NUM_PORTS-1:0] in_pkt;
    logic                  in_ready;
    logic                  out_commit;
    rvfi_pkt_t             out_pkt;
    logic [ORDER_W-1:0]    out_order;
    logic                  out_halt;
    logic                  wd_timeout;
    logic                  proto_err;

    modport master (
        output in_valid, in_pkt,
        input  in_ready, out_commit, out_pkt, out_order, out_halt, wd_timeout, proto_err
    );

    modport slave (
        input  in_valid, in_pkt,
        output in_ready, out_commit, out_pkt, out_order, out_halt, wd_timeout, proto_err
    );

endinterface

// File: rtl/rvfi_commit_fifo.sv
// Circular buffer accepting up to NUM_PORTS writes per cycle (in lane order) and one read.
module rvfi_commit_fifo
    import rvfi_mon_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(DEPTH):0]     wr_n,
    input  rvfi_pkt_t [NUM_PORTS-1:0]  wr_data,
    input  logic                       rd_en,
    output rvfi_pkt_t                  rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rvfi_pkt_t          mem_q [DEPTH];
    rvfi_pkt_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (CNT_W'(i) < wr_n) begin
                mem_d[wr_ptr_q + PTR_W'(i)] = wr_data[i];
            end
        end
        // Pointers wrap naturally because DEPTH is a power of two
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_n);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
        count_d  = count_q + wr_n - CNT_W'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/rvfi_commit_merger.sv
// Serialises multi-lane retirement packets onto one RVFI port, assigning order and
// detecting halt (branch-to-self), commit starvation and lane-contiguity violations.
module rvfi_commit_merger
    import rvfi_mon_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int DEPTH           = 8,
    parameter int HALT_REPEAT     = 1,
    parameter int WATCHDOG_CYCLES = 4096
) (
    input logic                 clk,
    input logic                 rst,
    rvfi_commit_merger_if.slave bus
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int LOOP_W = $clog2(HALT_REPEAT + 1);
    localparam int IDLE_W = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(WATCHDOG_CYCLES);

    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   n_enq;
    logic [CNT_W-1:0]   wr_n;
    logic               gap;
    logic               hole;
    logic               in_ready;
    logic               pop;
    logic               self_loop;
    rvfi_pkt_t          head;

    logic               out_commit_q, out_commit_d;
    rvfi_pkt_t          out_pkt_q, out_pkt_d;
    logic [ORDER_W-1:0] out_order_q, out_order_d;
    logic [ORDER_W-1:0] order_q, order_d;
    logic [LOOP_W-1:0]  loop_cnt_q, loop_cnt_d;
    logic               halted_q, halted_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic               wd_timeout_q, wd_timeout_d;
    logic               proto_err_q, proto_err_d;

    // Only the packed-low prefix of in_valid is accepted; anything above a hole is a protocol error
    always_comb begin
        n_enq = '0;
        gap   = 1'b0;
        hole  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.in_valid[i]) begin
                if (gap) hole = 1'b1;
                else     n_enq = n_enq + CNT_W'(1);
            end else begin
                gap = 1'b1;
            end
        end
    end

    assign in_ready = !halted_q && ((CNT_W'(DEPTH) - fifo_count) >= CNT_W'(NUM_PORTS));
    assign wr_n     = in_ready ? n_enq : '0;
    assign pop      = (fifo_count != '0) && !halted_q;
    assign self_loop = (head.pc_wdata == head.pc_rdata) && !head.trap;

    rvfi_commit_fifo #(
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_n    (wr_n),
        .wr_data (bus.in_pkt),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count)
    );

    always_comb begin
        out_commit_d = pop;
        out_pkt_d    = pop ? head : out_pkt_q;
        out_order_d  = pop ? order_q : out_order_q;
        order_d      = order_q + ORDER_W'(pop);
        loop_cnt_d   = loop_cnt_q;
        halted_d     = halted_q;
        if (pop) begin
            if (self_loop) begin
                loop_cnt_d = loop_cnt_q + LOOP_W'(1);
                if (loop_cnt_d == LOOP_W'(HALT_REPEAT)) halted_d = 1'b1;
            end else begin
                loop_cnt_d = '0;
            end
        end
        // Idle counter saturates at the limit and stops moving once halted
        idle_cnt_d = idle_cnt_q;
        if (!halted_q) begin
            if (out_commit_q)                idle_cnt_d = '0;
            else if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
        wd_timeout_d = wd_timeout_q | ((WATCHDOG_CYCLES != 0) && (idle_cnt_d == IDLE_MAX));
        proto_err_d  = proto_err_q | hole;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_commit_q <= 1'b0;
            out_pkt_q    <= '0;
            out_order_q  <= '0;
            order_q      <= '0;
            loop_cnt_q   <= '0;
            halted_q     <= 1'b0;
            idle_cnt_q   <= '0;
            wd_timeout_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            out_commit_q <= out_commit_d;
            out_pkt_q    <= out_pkt_d;
            out_order_q  <= out_order_d;
            order_q      <= order_d;
            loop_cnt_q   <= loop_cnt_d;
            halted_q     <= halted_d;
            idle_cnt_q   <= idle_cnt_d;
            wd_timeout_q <= wd_timeout_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_commit = out_commit_q;
    assign bus.out_pkt    = out_pkt_q;
    assign bus.out_order  = out_order_q;
    assign bus.out_halt   = halted_q;
    assign bus.wd_timeout = wd_timeout_q;
    assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_rvfi_commit_merger.sv
// Self-checking bench for rvfi_commit_merger: directed scenarios plus randomized traffic
// compared against a queue-based model of the merger's commit stream.
module tb_rvfi_commit_merger;
    import rvfi_mon_pkg::*;

    localparam int NP    = 2;
    localparam int DEPTH = 8;
    localparam int HR    = 2;
    localparam int WD    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    rvfi_commit_merger_if #(.NUM_PORTS(NP)) bus ();

    rvfi_commit_merger #(
        .NUM_PORTS       (NP),
        .DEPTH           (DEPTH),
        .HALT_REPEAT     (HR),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: in-order queue of accepted packets plus commit/halt bookkeeping
    rvfi_pkt_t   m_fifo[$];
    longint unsigned m_order;
    int          m_loop;
    bit          m_halted;

    logic        exp_ready, obs_ready, exp_commit, exp_halt;
    rvfi_pkt_t   exp_pkt;
    logic [63:0] exp_order;
    int          acc;

    function automatic rvfi_pkt_t make_pkt(input logic [31:0] pc);
        rvfi_pkt_t p;
        p.inst         = $urandom;
        p.trap         = ($urandom_range(0, 3) == 0);
        p.rs1_addr     = 5'($urandom);
        p.rs2_addr     = 5'($urandom);
        p.rs1_rdata    = $urandom;
        p.rs2_rdata    = $urandom;
        p.load_regfile = 1'($urandom);
        p.rd_addr      = 5'($urandom);
        p.rd_wdata     = $urandom;
        p.pc_rdata     = pc;
        p.pc_wdata     = pc + 32'd4;
        p.mem_addr     = $urandom;
        p.mem_rmask    = 4'($urandom);
        p.mem_wmask    = 4'($urandom);
        p.mem_rdata    = $urandom;
        p.mem_wdata    = $urandom;
        return p;
    endfunction

    // Drives one cycle of lanes, advances the model, and returns after the clock edge (+1)
    task automatic cycle(input logic [NP-1:0] v, input rvfi_pkt_t [NP-1:0] p);
        bit gap;
        exp_ready = !m_halted && ((DEPTH - m_fifo.size()) >= NP);
        obs_ready = bus.in_ready;
        bus.in_valid = v;
        bus.in_pkt   = p;
        exp_commit = 1'b0;
        if (m_fifo.size() > 0 && !m_halted) begin
            exp_commit = 1'b1;
            exp_pkt    = m_fifo.pop_front();
            exp_order  = m_order;
            m_order++;
            if (exp_pkt.pc_wdata == exp_pkt.pc_rdata && !exp_pkt.trap) m_loop++;
            else m_loop = 0;
            if (m_loop >= HR) m_halted = 1'b1;
        end
        exp_halt = m_halted;
        acc = 0;
        gap = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (v[i]) begin
                if (!gap && exp_ready) begin
                    m_fifo.push_back(p[i]);
                    acc++;
                end
            end else begin
                gap = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = '0;
    endtask

    task automatic reset_dut(input int n);
        rst = 1'b1;
        bus.in_valid = '0;
        bus.in_pkt   = '0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        m_fifo.delete();
        m_order  = 0;
        m_loop   = 0;
        m_halted = 1'b0;
    endtask

    task automatic test_reset;
        reset_dut(3);
        checks++; if (bus.out_commit !== 1'b0) begin failures++; $display("[TB] FAIL reset_commit got=%b exp=0", bus.out_commit); end
        checks++; if (bus.out_pkt !== '0) begin failures++; $display("[TB] FAIL reset_pkt got=%h exp=0", bus.out_pkt); end
        checks++; if (bus.out_order !== 64'd0) begin failures++; $display("[TB] FAIL reset_order got=%0d exp=0", bus.out_order); end
        checks++; if (bus.out_halt !== 1'b0) begin failures++; $display("[TB] FAIL reset_halt got=%b exp=0", bus.out_halt); end
        checks++; if (bus.wd_timeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_wd got=%b exp=0", bus.wd_timeout); end
        checks++; if (bus.proto_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_proto got=%b exp=0", bus.proto_err); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_order_lanes;
        rvfi_pkt_t [NP-1:0] p;
        reset_dut(1);
        p[0] = make_pkt(32'h60);
        p[1] = make_pkt(32'h64);
        cycle(2'b11, p);
        checks++; if (bus.out_commit !== 1'b0) begin failures++; $display("[TB] FAIL lanes_no_bypass got=%b exp=0", bus.out_commit); end
        cycle(2'b00, '0);
        checks++; if (bus.out_commit !== 1'b1 || bus.out_pkt.pc_rdata !== 32'h60 || bus.out_order !== 64'd0)
            begin failures++; $display("[TB] FAIL lanes_first got=%b/%h/%0d exp=1/60/0", bus.out_commit, bus.out_pkt.pc_rdata, bus.out_order); end
        checks++; if (bus.out_pkt !== p[0]) begin failures++; $display("[TB] FAIL lanes_pkt0 got=%h exp=%h", bus.out_pkt, p[0]); end
        cycle(2'b00, '0);
        checks++; if (bus.out_commit !== 1'b1 || bus.out_pkt.pc_rdata !== 32'h64 || bus.out_order !== 64'd1)
            begin failures++; $display("[TB] FAIL lanes_second got=%b/%h/%0d exp=1/64/1", bus.out_commit, bus.out_pkt.pc_rdata, bus.out_order); end
        cycle(2'b00, '0);
        checks++; if (bus.out_commit !== 1'b0) begin failures++; $display("[TB] FAIL lanes_drained got=%b exp=0", bus.out_commit); end
    endtask

    task automatic test_backpressure;
        rvfi_pkt_t [NP-1:0] p;
        logic [NP-1:0] v;
        int sent = 0, got = 0, low = 0, dut_commits = 0;
        reset_dut(1);
        p[0] = make_pkt(32'h1000);
        p[1] = make_pkt(32'h1004);
        for (int c = 0; c < 200 && got < 40; c++) begin
            v = (40 - sent >= 2) ? 2'b11 : ((40 - sent == 1) ? 2'b01 : 2'b00);
            cycle(v, p);
            if (acc > 0) begin
                sent += acc;
                p[0] = make_pkt(32'h1000 + 32'(4 * sent));
                p[1] = make_pkt(32'h1000 + 32'(4 * (sent + 1)));
            end
            if (!exp_ready) low++;
            dut_commits += int'(bus.out_commit === 1'b1);
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("[TB] FAIL bp_ready got=%b exp=%b", obs_ready, exp_ready); end
            checks++; if (bus.out_commit !== exp_commit) begin failures++; $display("[TB] FAIL bp_commit got=%b exp=%b", bus.out_commit, exp_commit); end
            if (exp_commit) begin
                checks++; if (bus.out_pkt !== exp_pkt) begin failures++; $display("[TB] FAIL bp_pkt got=%h exp=%h", bus.out_pkt, exp_pkt); end
                checks++; if (bus.out_pkt.pc_rdata !== 32'h1000 + 32'(4 * got) || bus.out_order !== 64'(got))
                    begin failures++; $display("[TB] FAIL bp_seq got=%h/%0d exp=%h/%0d", bus.out_pkt.pc_rdata, bus.out_order, 32'h1000 + 32'(4 * got), got); end
                got++;
            end
        end
        for (int c = 0; c < 3; c++) begin
            cycle(2'b00, '0);
            dut_commits += int'(bus.out_commit === 1'b1);
        end
        checks++; if (dut_commits != 40) begin failures++; $display("[TB] FAIL bp_total got=%0d exp=40", dut_commits); end
        checks++; if (low == 0) begin failures++; $display("[TB] FAIL bp_ready_drop got=0 exp>0"); end
    endtask

    task automatic test_halt;
        rvfi_pkt_t [NP-1:0] p;
        reset_dut(1);
        p[0] = make_pkt(32'h80);
        p[0].pc_wdata = 32'h80;
        p[0].trap     = 1'b0;
        p[1] = '0;
        cycle(2'b01, p);
        cycle(2'b01, p);
        checks++; if (bus.out_commit !== 1'b1 || bus.out_halt !== 1'b0)
            begin failures++; $display("[TB] FAIL halt_first got=%b/%b exp=1/0", bus.out_commit, bus.out_halt); end
        cycle(2'b00, '0);
        checks++; if (bus.out_commit !== 1'b1 || bus.out_halt !== 1'b1 || bus.out_order !== 64'd1)
            begin failures++; $display("[TB] FAIL halt_rise got=%b/%b/%0d exp=1/1/1", bus.out_commit, bus.out_halt, bus.out_order); end
        for (int c = 0; c < 4; c++) begin
            p[0] = make_pkt($urandom & 32'hFFFF_FFFC);
            p[1] = make_pkt($urandom & 32'hFFFF_FFFC);
            cycle(2'b11, p);
            checks++; if (obs_ready !== 1'b0) begin failures++; $display("[TB] FAIL halt_ready got=%b exp=0", obs_ready); end
            checks++; if (bus.out_commit !== 1'b0 || bus.out_halt !== 1'b1)
                begin failures++; $display("[TB] FAIL halt_frozen got=%b/%b exp=0/1", bus.out_commit, bus.out_halt); end
        end
    endtask

    task automatic test_watchdog_proto;
        rvfi_pkt_t [NP-1:0] p;
        reset_dut(1);
        for (int i = 1; i <= 20; i++) begin
            cycle(2'b00, '0);
            checks++; if (bus.wd_timeout !== logic'(i >= WD))
                begin failures++; $display("[TB] FAIL wd_cycle%0d got=%b exp=%b", i, bus.wd_timeout, i >= WD); end
        end
        checks++; if (bus.proto_err !== 1'b0) begin failures++; $display("[TB] FAIL proto_pre got=%b exp=0", bus.proto_err); end
        p[0] = make_pkt(32'h300);
        p[1] = make_pkt(32'h304);
        cycle(2'b10, p);
        checks++; if (bus.proto_err !== 1'b1) begin failures++; $display("[TB] FAIL proto_set got=%b exp=1", bus.proto_err); end
        for (int c = 0; c < 3; c++) begin
            cycle(2'b00, '0);
            checks++; if (bus.out_commit !== 1'b0) begin failures++; $display("[TB] FAIL proto_no_enq got=%b exp=0", bus.out_commit); end
        end
    endtask

    task automatic test_reset_midstream;
        rvfi_pkt_t [NP-1:0] p;
        reset_dut(1);
        for (int c = 0; c < 4; c++) begin
            p[0] = make_pkt(32'h100 + 32'(8 * c));
            p[1] = make_pkt(32'h104 + 32'(8 * c));
            cycle(2'b11, p);
        end
        checks++; if (bus.out_commit !== 1'b1 || bus.out_order !== 64'd2)
            begin failures++; $display("[TB] FAIL mid_pre got=%b/%0d exp=1/2", bus.out_commit, bus.out_order); end
        reset_dut(1);
        checks++; if (bus.out_commit !== 1'b0 || bus.out_order !== 64'd0 || bus.in_ready !== 1'b1)
            begin failures++; $display("[TB] FAIL mid_reset got=%b/%0d/%b exp=0/0/1", bus.out_commit, bus.out_order, bus.in_ready); end
        for (int c = 0; c < 3; c++) begin
            cycle(2'b00, '0);
            checks++; if (bus.out_commit !== 1'b0) begin failures++; $display("[TB] FAIL mid_flushed got=%b exp=0", bus.out_commit); end
        end
        p[0] = make_pkt(32'h200);
        p[1] = '0;
        cycle(2'b01, p);
        cycle(2'b00, '0);
        checks++; if (bus.out_commit !== 1'b1 || bus.out_order !== 64'd0 || bus.out_pkt.pc_rdata !== 32'h200)
            begin failures++; $display("[TB] FAIL mid_restart got=%b/%0d/%h exp=1/0/200", bus.out_commit, bus.out_order, bus.out_pkt.pc_rdata); end
    endtask

    task automatic test_random;
        rvfi_pkt_t [NP-1:0] p;
        logic [NP-1:0] v;
        reset_dut(1);
        for (int c = 0; c < 320; c++) begin
            for (int i = 0; i < NP; i++) begin
                p[i] = make_pkt($urandom & 32'hFFFF_FFFC);
                if ($urandom_range(0, 15) == 0) p[i].pc_wdata = p[i].pc_rdata;
            end
            v = (c < 300) ? NP'($urandom_range(0, 3)) : '0;
            cycle(v, p);
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("[TB] FAIL rnd_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
            checks++; if (bus.out_commit !== exp_commit) begin failures++; $display("[TB] FAIL rnd_commit c=%0d got=%b exp=%b", c, bus.out_commit, exp_commit); end
            checks++; if (bus.out_halt !== exp_halt) begin failures++; $display("[TB] FAIL rnd_halt c=%0d got=%b exp=%b", c, bus.out_halt, exp_halt); end
            if (exp_commit) begin
                checks++; if (bus.out_pkt !== exp_pkt) begin failures++; $display("[TB] FAIL rnd_pkt c=%0d got=%h exp=%h", c, bus.out_pkt, exp_pkt); end
                checks++; if (bus.out_order !== exp_order) begin failures++; $display("[TB] FAIL rnd_order c=%0d got=%0d exp=%0d", c, bus.out_order, exp_order); end
            end
        end
    endtask

    initial begin
        bus.in_valid = '0;
        bus.in_pkt   = '0;
        test_reset();
        test_order_lanes();
        test_backpressure();
        test_halt();
        test_watchdog_proto();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
